// File: rtl/boot_loader_if.sv
// rtl/boot_loader_if.sv - loader word stream between the host feeder and the boot loader
interface boot_loader_if;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_ready;

    modport slave  (input  s_valid, input  s_data, output s_ready);
    modport master (output s_valid, output s_data, input  s_ready);
endinterface

// File: rtl/boot_loader.sv
// rtl/boot_loader.sv - streams a counted, XOR-checked image into instruction memory, then releases the core
module boot_loader #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10,
    parameter int HOLD  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    boot_loader_if.slave      bus,
    output logic              imem_we,
    output logic [AW-1:0]     imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {IDLE, HDR, LOAD, CSUM, HOLDS, RUN, ERR} state_t;

    state_t        state_q, state_d;
    logic [AW:0]   n;
    logic [AW-1:0] cnt;
    logic [31:0]   csum;
    logic [7:0]    hold_cnt;
    logic          ready;
    logic          accept;
    logic          last;

    // Every output is decoded from the state register, never from the stream inputs.
    assign ready    = (state_q == HDR) || (state_q == LOAD) || (state_q == CSUM);
    assign accept   = bus.s_valid && ready;
    assign last     = ({1'b0, cnt} == (n - 1'b1));
    assign bus.s_ready = ready;
    assign core_rst = (state_q == RUN);
    assign done     = (state_q == RUN);
    assign err      = (state_q == ERR);

    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (start) state_d = HDR;
            HDR:   if (accept) begin
                       if (bus.s_data == 32'd0 || bus.s_data > 32'(DEPTH)) state_d = ERR;
                       else                                                state_d = LOAD;
                   end
            LOAD:  if (accept && last) state_d = CSUM;
            CSUM:  if (accept) state_d = (bus.s_data == csum) ? HOLDS : ERR;
            HOLDS: if (hold_cnt == 8'd0) state_d = RUN;
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            n          <= '0;
            cnt        <= '0;
            csum       <= '0;
            hold_cnt   <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            imem_we <= 1'b0;
            case (state_q)
                HDR: if (accept) begin
                    n    <= bus.s_data[AW:0];
                    cnt  <= '0;
                    csum <= '0;
                end
                LOAD: if (accept) begin
                    imem_we    <= 1'b1;
                    imem_addr  <= cnt;
                    imem_wdata <= bus.s_data;
                    csum       <= csum ^ bus.s_data;
                    // Counter parks at N-1 so the address never wraps.
                    if (!last) cnt <= cnt + 1'b1;
                end
                CSUM: if (accept) hold_cnt <= 8'(HOLD - 1);
                HOLDS: if (hold_cnt != 8'd0) hold_cnt <= hold_cnt - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
// tb/tb_boot_loader.sv - directed self-checking bench for boot_loader
module tb_boot_loader;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        imem_we;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        core_rst;
    logic        done;
    logic        err;

    boot_loader_if bus();

    boot_loader #(.DEPTH(1024), .AW(10), .HOLD(4)) dut (
        .clk(clk), .rst(rst), .start(start), .bus(bus),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .core_rst(core_rst), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    int          wr_count  = 0;
    logic [9:0]  last_addr = '0;
    logic [31:0] wmem [1024];
    logic [31:0] big  [1024];

    localparam logic [31:0] PROG [3] = '{32'h00500093, 32'h00300113, 32'h002081B3};

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wr_count++;
            last_addr = imem_addr;
            wmem[imem_addr] = imem_wdata;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b0;
        start = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data = '0;
        tick;
        rst = 1'b1;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic send(input logic [31:0] d, input logic exp_we, input int exp_addr, input bit chk);
        int guard = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        while (bus.s_ready !== 1'b1 && guard < 200) begin
            tick;
            guard++;
        end
        if (guard >= 200) begin
            total++;
            $display("FAIL send_timeout got s_ready=%b required 1 within 200 cycles", bus.s_ready);
        end else begin
            tick;
            if (chk) begin
                total++;
                if (imem_we !== exp_we)
                    $display("FAIL write_strobe word=%h got we=%b required %b", d, imem_we, exp_we);
                else if (exp_we && (imem_addr !== 10'(exp_addr) || imem_wdata !== d))
                    $display("FAIL write_payload got addr=%0d data=%h required addr=%0d data=%h",
                             imem_addr, imem_wdata, exp_addr, d);
                else passed++;
            end
        end
        bus.s_valid = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        rst = 1'b0;
        tick;
        total++;
        if ({bus.s_ready, imem_we, core_rst, done, err} !== 5'b0)
            $display("FAIL reset_flags got %b required 00000", {bus.s_ready, imem_we, core_rst, done, err});
        else passed++;
        total++;
        if (imem_addr !== 10'd0 || imem_wdata !== 32'd0)
            $display("FAIL reset_bus got addr=%0d data=%h required 0/0", imem_addr, imem_wdata);
        else passed++;
        rst = 1'b1;
    endtask

    task automatic test_idle_ignore;
        int base = wr_count;
        bus.s_valid = 1'b1;
        bus.s_data  = 32'd3;
        for (int i = 0; i < 4; i++) begin
            tick;
            total++;
            if (bus.s_ready !== 1'b0 || core_rst !== 1'b0)
                $display("FAIL idle_ready got s_ready=%b core_rst=%b required 0/0", bus.s_ready, core_rst);
            else passed++;
        end
        bus.s_valid = 1'b0;
        total++;
        if (wr_count - base !== 0) $display("FAIL idle_writes got %0d required 0", wr_count - base);
        else passed++;
    endtask

    task automatic test_good_load;
        int base;
        logic [31:0] cs = '0;
        do_reset;
        base = wr_count;
        pulse_start;
        send(32'd3, 1'b0, 0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cs ^= PROG[i];
            send(PROG[i], 1'b1, i, 1'b1);
        end
        send(cs, 1'b0, 0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (core_rst !== 1'b0 || done !== 1'b0 || bus.s_ready !== 1'b0)
                $display("FAIL hold_cycle%0d got core_rst=%b done=%b required 0/0", i, core_rst, done);
            else passed++;
            tick;
        end
        total++;
        if (core_rst !== 1'b1 || done !== 1'b1 || err !== 1'b0)
            $display("FAIL run_state got core_rst=%b done=%b err=%b required 1/1/0", core_rst, done, err);
        else passed++;
        total++;
        if (wr_count - base !== 3) $display("FAIL good_write_count got %0d required 3", wr_count - base);
        else passed++;
    endtask

    task automatic test_run_ignore;
        int base = wr_count;
        bus.s_valid = 1'b1;
        bus.s_data  = 32'h00000002;
        for (int i = 0; i < 5; i++) begin
            pulse_start;
            total++;
            if (bus.s_ready !== 1'b0 || done !== 1'b1 || core_rst !== 1'b1)
                $display("FAIL run_ignore got s_ready=%b done=%b core_rst=%b required 0/1/1",
                         bus.s_ready, done, core_rst);
            else passed++;
        end
        bus.s_valid = 1'b0;
        total++;
        if (wr_count - base !== 0) $display("FAIL run_writes got %0d required 0", wr_count - base);
        else passed++;
    endtask

    task automatic test_bad_csum;
        int base;
        do_reset;
        base = wr_count;
        pulse_start;
        send(32'd3, 1'b0, 0, 1'b1);
        for (int i = 0; i < 3; i++) send(PROG[i], 1'b1, i, 1'b1);
        send(32'h00000000, 1'b0, 0, 1'b1);
        total++;
        if (err !== 1'b1 || done !== 1'b0 || core_rst !== 1'b0)
            $display("FAIL bad_csum got err=%b done=%b core_rst=%b required 1/0/0", err, done, core_rst);
        else passed++;
        repeat (6) tick;
        total++;
        if (err !== 1'b1 || core_rst !== 1'b0)
            $display("FAIL err_sticky got err=%b core_rst=%b required 1/0", err, core_rst);
        else passed++;
        total++;
        if (wr_count - base !== 3) $display("FAIL bad_csum_writes got %0d required 3", wr_count - base);
        else passed++;
    endtask

    task automatic test_bad_count(input logic [31:0] c);
        int base;
        do_reset;
        base = wr_count;
        pulse_start;
        send(c, 1'b0, 0, 1'b1);
        total++;
        if (err !== 1'b1 || bus.s_ready !== 1'b0)
            $display("FAIL bad_count_%0d got err=%b s_ready=%b required 1/0", c, err, bus.s_ready);
        else passed++;
        bus.s_valid = 1'b1;
        bus.s_data  = 32'h12345678;
        repeat (4) tick;
        bus.s_valid = 1'b0;
        total++;
        if (wr_count - base !== 0) $display("FAIL bad_count_writes got %0d required 0", wr_count - base);
        else passed++;
    endtask

    task automatic test_mid_reset;
        int base;
        do_reset;
        base = wr_count;
        pulse_start;
        send(32'd5, 1'b0, 0, 1'b1);
        send(32'hAAAA0001, 1'b1, 0, 1'b1);
        send(32'hAAAA0002, 1'b1, 1, 1'b1);
        rst = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data  = 32'hAAAA0003;
        tick;
        total++;
        if ({bus.s_ready, imem_we, core_rst, done, err} !== 5'b0 || imem_addr !== 10'd0 || imem_wdata !== 32'd0)
            $display("FAIL mid_reset got flags=%b addr=%0d data=%h required 00000/0/0",
                     {bus.s_ready, imem_we, core_rst, done, err}, imem_addr, imem_wdata);
        else passed++;
        rst = 1'b1;
        bus.s_valid = 1'b0;
        tick;
        total++;
        if (wr_count - base !== 2) $display("FAIL mid_reset_writes got %0d required 2", wr_count - base);
        else passed++;
        pulse_start;
        send(32'd2, 1'b0, 0, 1'b1);
        send(32'hC0DE0000, 1'b1, 0, 1'b1);
        pulse_start;
        send(32'h0000BEEF, 1'b1, 1, 1'b1);
        send(32'hC0DEBEEF, 1'b0, 0, 1'b1);
        repeat (4) tick;
        total++;
        if (done !== 1'b1 || core_rst !== 1'b1 || wr_count - base !== 4)
            $display("FAIL reload got done=%b core_rst=%b writes=%0d required 1/1/4", done, core_rst, wr_count - base);
        else passed++;
    endtask

    task automatic test_full_depth;
        int base;
        int bad = 0;
        logic [31:0] cs = '0;
        do_reset;
        base = wr_count;
        pulse_start;
        send(32'd1024, 1'b0, 0, 1'b1);
        for (int i = 0; i < 1024; i++) begin
            repeat ($urandom_range(0, 2)) tick;
            big[i] = $urandom;
            cs ^= big[i];
            send(big[i], 1'b1, i, 1'b0);
        end
        send(cs, 1'b0, 0, 1'b1);
        repeat (5) tick;
        total++;
        if (done !== 1'b1 || err !== 1'b0) $display("FAIL full_done got done=%b err=%b required 1/0", done, err);
        else passed++;
        total++;
        if (wr_count - base !== 1024 || last_addr !== 10'd1023)
            $display("FAIL full_writes got count=%0d last=%0d required 1024/1023", wr_count - base, last_addr);
        else passed++;
        for (int i = 0; i < 1024; i++) if (wmem[i] !== big[i]) bad++;
        total++;
        if (bad !== 0) $display("FAIL full_contents got %0d bad words required 0", bad);
        else passed++;
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data = '0;
        test_reset;
        test_idle_ignore;
        test_good_load;
        test_run_ignore;
        test_bad_csum;
        test_bad_count(32'd0);
        test_bad_count(32'd1025);
        test_mid_reset;
        test_full_depth;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
